// File: rtl/vga_pattern_pkg.sv
// ---------------------------------------------------------------------------
// vga_pattern_pkg
//   Shared definitions for the VGA scrolling test-pattern engine:
//   - pattern mode encodings (mode_e)
//   - default 640x480@60 timing constants
//   - rgb222_t colour struct (2 bits per channel)
//   - dim_rgb(): halves each channel (used by the optional scanline effect)
// ---------------------------------------------------------------------------
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_STRIPES = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_DIAG    = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  function automatic rgb222_t dim_rgb(input rgb222_t c);
    rgb222_t d;
    d.r = c.r >> 1;
    d.g = c.g >> 1;
    d.b = c.b >> 1;
    return d;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Free-running raster counters and unregistered sync/active decode.
//   Ports:
//     clk, rst_n            pixel clock, synchronous active-low reset
//     hpos, vpos            current pixel position
//     hsync, vsync          sync level for the current position (SYNC_POL = active)
//     active                current position is inside the visible area
//     frame_tick            one-cycle pulse on the last pixel of the frame
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_pattern_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          frame_tick
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos <= '0;
      vpos <= '0;
    end else if (hpos == H_LAST) begin
      hpos <= '0;
      vpos <= (vpos == V_LAST) ? '0 : vpos + 1'b1;
    end else begin
      hpos <= hpos + 1'b1;
    end
  end

  assign hsync      = (hpos >= HS_START && hpos <= HS_END) ? SYNC_POL : ~SYNC_POL;
  assign vsync      = (vpos >= VS_START && vpos <= VS_END) ? SYNC_POL : ~SYNC_POL;
  assign active     = (hpos < H_VIS) && (vpos < V_VIS);
  assign frame_tick = (hpos == H_LAST) && (vpos == V_LAST);

endmodule

// File: rtl/vga_scroll_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_scroll_pattern_gen
//   Scrolling VGA test-pattern engine (2 bits per colour channel).
//   Ports:
//     clk, rst_n            pixel clock, synchronous active-low reset
//     mode[1:0]             0 stripes, 1 checker, 2 diagonal, 3 solid-cycle
//     speed[2:0]            scroll step per frame in pixels
//     dir_x, dir_y          0 = offset increments, 1 = offset decrements
//     freeze                hold both offsets (frame counter keeps running)
//     hsync, vsync, de      registered sync / display enable
//     r, g, b               registered colour, zero during blanking
//     frame_cnt             frames completed since reset (wraps)
//   Build option:
//     VGA_SCANLINE_EN       when defined, odd lines show each channel halved
//   Controls are captured into shadow registers on the last pixel of each
//   frame so a frame is always drawn with one consistent setting.
// ---------------------------------------------------------------------------
module vga_scroll_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int OFFSET_W = 10,
  parameter int FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [2:0]         speed,
  input  logic               dir_x,
  input  logic               dir_y,
  input  logic               freeze,
  output logic               hsync,
  output logic               vsync,
  output logic [1:0]         r,
  output logic [1:0]         g,
  output logic [1:0]         b,
  output logic               de,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic          hsync_c;
  logic          vsync_c;
  logic          active;
  logic          frame_tick;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .hpos       (hpos),
    .vpos       (vpos),
    .hsync      (hsync_c),
    .vsync      (vsync_c),
    .active     (active),
    .frame_tick (frame_tick)
  );

  mode_e               sh_mode;
  logic [2:0]          sh_speed;
  logic                sh_dir_x;
  logic                sh_dir_y;
  logic                sh_freeze;
  logic [OFFSET_W-1:0] offset_x;
  logic [OFFSET_W-1:0] offset_y;
  logic [OFFSET_W-1:0] speed_ext;

  assign speed_ext = OFFSET_W'(sh_speed);

  // Offsets advance with the settings of the frame that just finished; the
  // new inputs are captured at the same tick and take effect one frame later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_mode   <= MODE_STRIPES;
      sh_speed  <= '0;
      sh_dir_x  <= 1'b0;
      sh_dir_y  <= 1'b0;
      sh_freeze <= 1'b0;
      offset_x  <= '0;
      offset_y  <= '0;
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + 1'b1;
      if (!sh_freeze) begin
        offset_x <= sh_dir_x ? offset_x - speed_ext : offset_x + speed_ext;
        offset_y <= sh_dir_y ? offset_y - speed_ext : offset_y + speed_ext;
      end
      sh_mode   <= mode_e'(mode);
      sh_speed  <= speed;
      sh_dir_x  <= dir_x;
      sh_dir_y  <= dir_y;
      sh_freeze <= freeze;
    end
  end

  logic [OFFSET_W-1:0] mx;
  logic [OFFSET_W-1:0] my;
  logic [OFFSET_W-1:0] s;
  logic                chk;
  logic                unused_s;
  rgb222_t             pix;

  assign mx       = OFFSET_W'(hpos) + offset_x;
  assign my       = OFFSET_W'(vpos) + offset_y;
  assign s        = mx + my;
  assign chk      = mx[5] ^ my[5];
  assign unused_s = ^s;

  always_comb begin
    pix = '0;
    case (sh_mode)
      MODE_STRIPES: begin
        pix.r = {mx[5], my[2]};
        pix.g = {mx[6], my[2]};
        pix.b = {mx[7], my[5]};
      end
      MODE_CHECKER: pix = rgb222_t'({6{chk}});
      MODE_DIAG: begin
        pix.r = s[6:5];
        pix.g = s[7:6];
        pix.b = s[8:7];
      end
      MODE_SOLID:   pix = rgb222_t'(frame_cnt[7:2]);
      default:      pix = '0;
    endcase
    if (!active) begin
      pix = '0;
    end
`ifdef VGA_SCANLINE_EN
    if (vpos[0]) begin
      pix = dim_rgb(pix);
    end
`else
`endif
  end

  // One register stage for every output keeps sync, enable and colour aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      de    <= 1'b0;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else begin
      hsync <= hsync_c;
      vsync <= vsync_c;
      de    <= active;
      r     <= pix.r;
      g     <= pix.g;
      b     <= pix.b;
    end
  end

endmodule
